free_reg_list: RTL

- Free register list (FRL) supplying physical register indices to the rename stage.
- Holds unallocated physical registers in a circular FIFO.
- Presents a window of ALLOC_WIDTH staged indices (dest, immediate, NZCV per lane) to rename.
- Refills consumed window slots and accepts released registers from ROB commit.

---
 rtl/reg_pkg.sv | 14 +
 rtl/phys_reg_fifo.sv | 69 ++++++
 rtl/free_reg_list.sv | 117 +++++++++++
 3 files changed

// File: rtl/reg_pkg.sv
// Physical register file sizing shared by rename and the free register list.
// The FRL window width is exported so rename can size its consume strobes.
package reg_pkg;

    localparam int NUM_PHYS_REGS   = 64;
    localparam int INSTR_Q_WIDTH   = 2;
    localparam int FRL_ALLOC_WIDTH = 3 * INSTR_Q_WIDTH;
    localparam int PHYS_IDX_W      = $clog2(NUM_PHYS_REGS);
    localparam int PHYS_CNT_W      = $clog2(NUM_PHYS_REGS + 1);

    typedef logic [PHYS_IDX_W-1:0] phys_reg_t;
    typedef logic [PHYS_CNT_W-1:0] phys_cnt_t;

endpackage

// File: rtl/phys_reg_fifo.sv
// Circular buffer of free physical indices with a multi-entry read window,
// a variable pop count and a sparse multi-lane push vector.
module phys_reg_fifo #(
    parameter int DEPTH  = 64,
    parameter int POP_W  = 6,
    parameter int PUSH_W = 2,
    localparam int IW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(POP_W + 1)
) (
    input  logic                         clk,
    input  logic                         rst_in,
    input  logic [PW-1:0]                pop_n_i,
    input  logic [PUSH_W-1:0]            push_vld_i,
    input  logic [PUSH_W-1:0][IW-1:0]    push_data_i,
    output logic [POP_W-1:0][IW-1:0]     win_o,
    output logic [CW-1:0]                count_o
);

    logic [IW-1:0] mem_q [DEPTH];
    logic [IW-1:0] head_q, head_d;
    logic [IW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] wr_addr [PUSH_W];
    logic [CW-1:0] push_n;

    function automatic logic [IW-1:0] wrap(input logic [IW-1:0] b,
                                           input int unsigned off);
        int unsigned s;
        s = int'(b) + off;
        if (s >= DEPTH) s = s - DEPTH;
        return IW'(s);
    endfunction

    always_comb begin
        int unsigned n;
        n = 0;
        for (int j = 0; j < PUSH_W; j++) begin
            wr_addr[j] = wrap(tail_q, n);
            if (push_vld_i[j]) n = n + 1;
        end
        push_n  = CW'(n);
        head_d  = wrap(head_q, int'(pop_n_i));
        tail_d  = wrap(tail_q, n);
        count_d = count_q - CW'(pop_n_i) + push_n;
        for (int i = 0; i < POP_W; i++) begin
            win_o[i] = mem_q[wrap(head_q, i)];
        end
    end

    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= IW'(i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CW'(DEPTH);
        end else begin
            for (int j = 0; j < PUSH_W; j++) begin
                if (push_vld_i[j]) mem_q[wr_addr[j]] <= push_data_i[j];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/free_reg_list.sv
// Free register list: stages a window of free physical indices for rename,
// refills consumed slots each edge and absorbs releases from ROB commit.
module free_reg_list #(
    parameter int NUM_PHYS_REGS = reg_pkg::NUM_PHYS_REGS,
    parameter int INSTR_Q_WIDTH = reg_pkg::INSTR_Q_WIDTH,
    parameter int ALLOC_WIDTH   = 3 * INSTR_Q_WIDTH,
    parameter int FREE_WIDTH    = INSTR_Q_WIDTH,
    localparam int IW = $clog2(NUM_PHYS_REGS),
    localparam int CW = $clog2(NUM_PHYS_REGS + 1),
    localparam int PW = $clog2(ALLOC_WIDTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst_in,
    input  logic [ALLOC_WIDTH-1:0]         frl_ready,
    output logic [ALLOC_WIDTH-1:0][IW-1:0] free_register_data,
    output logic                           frl_valid,
    input  logic [FREE_WIDTH-1:0]          free_valid,
    input  logic [FREE_WIDTH-1:0][IW-1:0]  free_reg,
    output logic [CW-1:0]                  free_count,
    output logic                           err_overflow,
    output logic                           err_bad_consume
);

    logic [ALLOC_WIDTH-1:0][IW-1:0] slot_data_q, slot_data_d;
    logic [ALLOC_WIDTH-1:0]         slot_vld_q, slot_vld_d;
    logic                           err_ovf_q, err_ovf_d;
    logic                           err_bad_q, err_bad_d;

    logic [ALLOC_WIDTH-1:0][IW-1:0] win;
    logic [CW-1:0]                  fifo_cnt;
    logic [PW-1:0]                  pop_n;
    logic [FREE_WIDTH-1:0]          push_ok;
    logic [ALLOC_WIDTH-1:0]         cons, vld_c;

    phys_reg_fifo #(
        .DEPTH  (NUM_PHYS_REGS),
        .POP_W  (ALLOC_WIDTH),
        .PUSH_W (FREE_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst_in      (rst_in),
        .pop_n_i     (pop_n),
        .push_vld_i  (push_ok),
        .push_data_i (free_reg),
        .win_o       (win),
        .count_o     (fifo_cnt)
    );

    assign frl_valid          = &slot_vld_q;
    assign free_register_data = slot_data_q;
    assign err_overflow       = err_ovf_q;
    assign err_bad_consume    = err_bad_q;

    always_comb begin
        int pc;
        pc = 0;
        for (int k = 0; k < ALLOC_WIDTH; k++) pc = pc + int'(slot_vld_q[k]);
        free_count = CW'(int'(fifo_cnt) + pc);
    end

    always_comb begin
        int rank;
        int held;
        logic drop;
        cons        = frl_ready & {ALLOC_WIDTH{frl_valid}};
        vld_c       = slot_vld_q & ~cons;
        slot_vld_d  = vld_c;
        slot_data_d = slot_data_q;
        rank        = 0;
        held        = 0;
        drop        = 1'b0;
        push_ok     = '0;
        // Empty slots take window entries in ascending order: rank = fill index
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            if (vld_c[k]) begin
                held = held + 1;
            end else if (rank < int'(fifo_cnt)) begin
                for (int r = 0; r < ALLOC_WIDTH; r++) begin
                    if (r == rank) slot_data_d[k] = win[r];
                end
                slot_vld_d[k] = 1'b1;
                rank = rank + 1;
            end
        end
        pop_n = PW'(rank);
        // Filling only moves entries between FIFO and slots, so the bound
        // uses the start-of-cycle FIFO count plus slots surviving consume.
        held = held + int'(fifo_cnt);
        for (int j = 0; j < FREE_WIDTH; j++) begin
            if (free_valid[j]) begin
                if (held < NUM_PHYS_REGS) begin
                    push_ok[j] = 1'b1;
                    held = held + 1;
                end else begin
                    drop = 1'b1;
                end
            end
        end
        err_ovf_d = err_ovf_q | drop;
        err_bad_d = err_bad_q | ((|frl_ready) & ~frl_valid);
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            slot_data_q <= '0;
            slot_vld_q  <= '0;
            err_ovf_q   <= 1'b0;
            err_bad_q   <= 1'b0;
        end else begin
            slot_data_q <= slot_data_d;
            slot_vld_q  <= slot_vld_d;
            err_ovf_q   <= err_ovf_d;
            err_bad_q   <= err_bad_d;
        end
    end

endmodule
